// File: rtl/dsm2_stim_gen.sv
// Filter-row stimulus source (zero / 2nd-order DSM / PRBS15 / alternating) with one registered bit per enabled clk.
// Latency 1 clk from state to pins; no backpressure; bit replicated onto lane-masked pins.
module dsm2_stim_gen #(
   parameter int NUM_OUTPUTS = 24,
   parameter int CODE_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic [1:0]             mode,
   input  logic [CODE_WIDTH-1:0]  code,
   input  logic                   code_load,
   input  logic [NUM_OUTPUTS-1:0] lane_mask,
   output logic [NUM_OUTPUTS-1:0] bitstream,
   output logic [CODE_WIDTH-1:0]  code_active,
   output logic [15:0]            sample_cnt
);
   localparam int I1W = CODE_WIDTH + 2;
   localparam int I2W = CODE_WIDTH + 4;
   localparam int SW  = CODE_WIDTH + 6;

   localparam logic [1:0]  MODE_ZERO = 2'b00;
   localparam logic [1:0]  MODE_DSM  = 2'b01;
   localparam logic [1:0]  MODE_PRBS = 2'b10;
   localparam logic [1:0]  MODE_ALT  = 2'b11;
   localparam logic [14:0] LFSR_SEED = 15'h7FFF;

   localparam logic signed [SW-1:0] FB_MAG = SW'(64'sd1 <<< (CODE_WIDTH - 1));
   localparam logic signed [SW-1:0] I1_MAX = SW'((64'sd1 <<< (I1W - 1)) - 64'sd1);
   localparam logic signed [SW-1:0] I1_MIN = SW'(-(64'sd1 <<< (I1W - 1)));
   localparam logic signed [SW-1:0] I2_MAX = SW'((64'sd1 <<< (I2W - 1)) - 64'sd1);
   localparam logic signed [SW-1:0] I2_MIN = SW'(-(64'sd1 <<< (I2W - 1)));

   logic signed [I1W-1:0]   r_i1;
   logic signed [I2W-1:0]   r_i2;
   logic [14:0]             r_lfsr;
   logic                    r_tog;
   logic [1:0]              r_prev_mode;
   logic [CODE_WIDTH-1:0]   r_code_active;
   logic [15:0]             r_sample_cnt;
   logic [NUM_OUTPUTS-1:0]  r_bitstream;

   logic                    w_mode_chg;
   logic                    w_run;
   logic                    w_y;
   logic signed [SW-1:0]    w_fb;
   logic signed [SW-1:0]    w_i1_sum;
   logic signed [SW-1:0]    w_i2_sum;
   logic signed [I1W-1:0]   w_i1_next;
   logic signed [I2W-1:0]   w_i2_next;

   function automatic logic signed [I1W-1:0] sat_i1(input logic signed [SW-1:0] v);
      logic signed [SW-1:0] c;
      if (v > I1_MAX)      c = I1_MAX;
      else if (v < I1_MIN) c = I1_MIN;
      else                 c = v;
      return c[I1W-1:0];
   endfunction

   function automatic logic signed [I2W-1:0] sat_i2(input logic signed [SW-1:0] v);
      logic signed [SW-1:0] c;
      if (v > I2_MAX)      c = I2_MAX;
      else if (v < I2_MIN) c = I2_MIN;
      else                 c = v;
      return c[I2W-1:0];
   endfunction

   // A mode change edge only re-initialises state; it never emits a bit.
   assign w_mode_chg = (mode != r_prev_mode);
   assign w_run      = enable && (mode != MODE_ZERO) && !w_mode_chg;

   always_comb begin
      case (mode)
         MODE_DSM:  w_y = ~r_i2[I2W-1];
         MODE_PRBS: w_y = r_lfsr[14];
         MODE_ALT:  w_y = r_tog;
         default:   w_y = 1'b0;
      endcase
   end

   // i2 is updated with the already-saturated i1, not the raw sum.
   assign w_fb      = w_y ? FB_MAG : -FB_MAG;
   assign w_i1_sum  = SW'(r_i1) + SW'($signed(r_code_active)) - w_fb;
   assign w_i1_next = sat_i1(w_i1_sum);
   assign w_i2_sum  = SW'(r_i2) + SW'(w_i1_next) - w_fb;
   assign w_i2_next = sat_i2(w_i2_sum);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev_mode   <= MODE_ZERO;
         r_code_active <= '0;
         r_sample_cnt  <= '0;
         r_i1          <= '0;
         r_i2          <= '0;
         r_lfsr        <= LFSR_SEED;
         r_tog         <= 1'b1;
         r_bitstream   <= '0;
      end else begin
         r_prev_mode <= mode;
         if (code_load) r_code_active <= code;

         if (code_load || w_mode_chg)
            r_sample_cnt <= '0;
         else if (w_run && (r_sample_cnt != 16'hFFFF))
            r_sample_cnt <= r_sample_cnt + 16'd1;

         if (w_mode_chg) begin
            r_i1        <= '0;
            r_i2        <= '0;
            r_lfsr      <= LFSR_SEED;
            r_tog       <= 1'b1;
            r_bitstream <= '0;
         end else if (w_run) begin
            r_bitstream <= {NUM_OUTPUTS{w_y}} & lane_mask;
            case (mode)
               MODE_DSM: begin
                  r_i1 <= w_i1_next;
                  r_i2 <= w_i2_next;
               end
               MODE_PRBS: r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
               MODE_ALT:  r_tog  <= ~r_tog;
               default:   ;
            endcase
         end else begin
            r_bitstream <= '0;
         end
      end
   end

   assign bitstream   = r_bitstream;
   assign code_active = r_code_active;
   assign sample_cnt  = r_sample_cnt;
endmodule
